// File: rtl/clock_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : clock_phase_gen
// Description : Multi-channel clock-enable / phase generator. Each channel
//               divides the system clock by a programmable ratio, producing a
//               one-cycle enable pulse at terminal count and a square wave
//               toggling on that pulse. Ratios change glitch-free at period
//               boundaries; channels can be frozen or realigned together.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_phase_gen #(
  parameter int                      NUM_CH   = 3,
  parameter int                      CNT_W    = 8,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {8'd4, 8'd2, 8'd1}
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH*CNT_W-1:0] div_sel,
  input  logic                    load,
  input  logic                    hold_req,
  input  logic                    sync_clr,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       phase_out,
  output logic                    load_busy,
  output logic                    hold_ack
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_freeze;
  logic              w_capture;
  logic [NUM_CH-1:0] w_pend_valid;

  // Shared RUN/HOLD state register; hold_ack is simply the registered state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; channels freeze on the same edge that enters HOLD so
  // the frozen window lines up exactly with hold_ack.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if (hold_req)  w_state_next = ST_HOLD;
      ST_HOLD: if (!hold_req) w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
    w_freeze = (w_state_next == ST_HOLD);
  end

  // A load is accepted when idle, or alongside sync_clr, which empties the
  // pending set first so the load becomes a fresh pending set.
  assign w_capture = load & (sync_clr | ~load_busy);
  assign load_busy = |w_pend_valid;
  assign hold_ack  = (r_state == ST_HOLD);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend;
    logic             r_pv;
    logic             r_en;
    logic             r_ph;
    logic [CNT_W-1:0] w_last;
    logic             w_tc;

    // A ratio of 0 behaves as 1, so its last count is 0 as well.
    assign w_last = (r_div == '0) ? '0 : (r_div - 1'b1);
    assign w_tc   = (r_cnt >= w_last);

    // Per-channel counter, ratio swap at terminal count, enable and phase.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_cnt  <= '0;
        r_div  <= DIV_INIT[k*CNT_W +: CNT_W];
        r_pend <= DIV_INIT[k*CNT_W +: CNT_W];
        r_pv   <= 1'b0;
        r_en   <= 1'b0;
        r_ph   <= 1'b0;
      end else begin
        if (sync_clr) begin
          r_cnt <= '0;
          r_en  <= 1'b0;
          r_ph  <= 1'b0;
          if (r_pv) r_div <= r_pend;
          r_pv  <= 1'b0;
        end else if (w_freeze) begin
          r_en  <= 1'b0;
        end else if (w_tc) begin
          r_cnt <= '0;
          r_en  <= 1'b1;
          r_ph  <= ~r_ph;
          if (r_pv) r_div <= r_pend;
          r_pv  <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          r_en  <= 1'b0;
        end
        if (w_capture) begin
          r_pend <= div_sel[k*CNT_W +: CNT_W];
          r_pv   <= 1'b1;
        end
      end
    end

    assign clk_en[k]       = r_en;
    assign phase_out[k]    = r_ph;
    assign w_pend_valid[k] = r_pv;
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_phase_gen
// Description : Self-checking bench for clock_phase_gen. Directed scenarios
//               followed by randomized control traffic, compared every cycle
//               against a behavioural per-channel period model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_phase_gen;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT = {8'd4, 8'd2, 8'd1};

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [NUM_CH*CNT_W-1:0] div_sel = '0;
  logic                    load = 1'b0;
  logic                    hold_req = 1'b0;
  logic                    sync_clr = 1'b0;
  logic [NUM_CH-1:0]       clk_en;
  logic [NUM_CH-1:0]       phase_out;
  logic                    load_busy;
  logic                    hold_ack;

  int checks = 0;
  int errors = 0;

  // Model: position within the current period, active and pending ratios.
  int m_pos  [NUM_CH];
  int m_div  [NUM_CH];
  int m_pend [NUM_CH];
  bit m_pv   [NUM_CH];
  bit m_en   [NUM_CH];
  bit m_ph   [NUM_CH];
  bit m_hack;

  clock_phase_gen #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DIV_INIT(DIV_INIT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .div_sel  (div_sel),
    .load     (load),
    .hold_req (hold_req),
    .sync_clr (sync_clr),
    .clk_en   (clk_en),
    .phase_out(phase_out),
    .load_busy(load_busy),
    .hold_ack (hold_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_pos[k]  = 0;
      m_div[k]  = int'(DIV_INIT[k*CNT_W +: CNT_W]);
      m_pend[k] = m_div[k];
      m_pv[k]   = 1'b0;
      m_en[k]   = 1'b0;
      m_ph[k]   = 1'b0;
    end
    m_hack = 1'b0;
  endtask

  function automatic bit model_busy();
    bit b = 1'b0;
    for (int k = 0; k < NUM_CH; k++) b |= m_pv[k];
    return b;
  endfunction

  // Predict the state after the coming rising edge from the current inputs.
  task automatic model_step();
    bit busy_before = model_busy();
    for (int k = 0; k < NUM_CH; k++) begin
      int period = (m_div[k] == 0) ? 1 : m_div[k];
      if (sync_clr) begin
        m_pos[k] = 0; m_en[k] = 0; m_ph[k] = 0;
        if (m_pv[k]) m_div[k] = m_pend[k];
        m_pv[k] = 0;
      end else if (hold_req) begin
        m_en[k] = 0;
      end else if (m_pos[k] + 1 == period) begin
        m_pos[k] = 0; m_en[k] = 1; m_ph[k] = !m_ph[k];
        if (m_pv[k]) m_div[k] = m_pend[k];
        m_pv[k] = 0;
      end else begin
        m_pos[k] = m_pos[k] + 1; m_en[k] = 0;
      end
    end
    if (load && (sync_clr || !busy_before)) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_pend[k] = int'(div_sel[k*CNT_W +: CNT_W]);
        m_pv[k]   = 1'b1;
      end
    end
    m_hack = hold_req;
  endtask

  task automatic check_all(input string tag);
    logic [NUM_CH-1:0] e_en, e_ph;
    for (int k = 0; k < NUM_CH; k++) begin
      e_en[k] = m_en[k];
      e_ph[k] = m_ph[k];
    end
    chk({tag, ".clk_en"},    32'(clk_en),    32'(e_en));
    chk({tag, ".phase_out"}, 32'(phase_out), 32'(e_ph));
    chk({tag, ".load_busy"}, 32'(load_busy), 32'(model_busy()));
    chk({tag, ".hold_ack"},  32'(hold_ack),  32'(m_hack));
  endtask

  task automatic run_cycle(input string tag);
    model_step();
    @(negedge clock);
    check_all(tag);
  endtask

  initial begin
    int guard;
    // Reset state while reset is held low.
    model_reset();
    #2 check_all("reset_async");
    @(negedge clock);
    @(negedge clock);
    check_all("reset_held");
    reset = 1'b1;

    // Defaults with no stimulus.
    repeat (16) run_cycle("defaults");

    // Load ch1 ratio 5 while ch1 sits at count 0.
    guard = 0;
    while (m_pos[1] != 0 && guard < 20) begin run_cycle("align1"); guard++; end
    div_sel = {8'd4, 8'd5, 8'd1};
    load = 1'b1; run_cycle("load5"); load = 1'b0;
    repeat (24) run_cycle("ratio5");

    // Freeze for 10 cycles, then resume.
    hold_req = 1'b1;
    repeat (10) run_cycle("hold");
    hold_req = 1'b0;
    repeat (10) run_cycle("resume");

    // sync_clr with a load outstanding.
    div_sel = {8'd3, 8'd3, 8'd2};
    load = 1'b1; run_cycle("load_pend"); load = 1'b0;
    sync_clr = 1'b1; run_cycle("sync"); sync_clr = 1'b0;
    repeat (12) run_cycle("post_sync");

    // load and sync_clr together, then sync_clr inside HOLD.
    div_sel = {8'd2, 8'd1, 8'd3};
    load = 1'b1; sync_clr = 1'b1; run_cycle("load_sync");
    load = 1'b0; sync_clr = 1'b0;
    hold_req = 1'b1; repeat (3) run_cycle("hold2");
    sync_clr = 1'b1; run_cycle("sync_in_hold"); sync_clr = 1'b0;
    repeat (2) run_cycle("hold2b");
    hold_req = 1'b0; repeat (8) run_cycle("resume2");

    // Ratio 0 on ch0 behaves as ratio 1.
    div_sel = {8'd4, 8'd2, 8'd0};
    load = 1'b1; run_cycle("load0"); load = 1'b0;
    repeat (12) run_cycle("ratio0");

    // Asynchronous reset mid-period with ch2 at count 3.
    guard = 0;
    while (m_pos[2] != 3 && guard < 40) begin run_cycle("align2"); guard++; end
    chk("align_ch2_cnt3", 32'(guard < 40), 32'd1);
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("reset_mid");
    @(negedge clock);
    check_all("reset_mid_held");
    reset = 1'b1;
    repeat (16) run_cycle("after_reset");

    // Randomized control traffic.
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < NUM_CH; k++) div_sel[k*CNT_W +: CNT_W] = 8'($urandom_range(0, 6));
      load     = ($urandom_range(0, 7) == 0);
      sync_clr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 19) == 0) hold_req = ~hold_req;
      run_cycle("random");
    end
    load = 1'b0; sync_clr = 1'b0; hold_req = 1'b0;
    repeat (4) run_cycle("drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
